// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory arbiter: owner encoding,
// the no-write byte-enable value and word alignment.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    localparam logic [3:0]  BYTEEN_NONE = 4'b0000;
    localparam logic [31:0] WORD_MASK   = 32'hffff_fffc;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/dm_bus_arbiter_if.sv
// Bus bundle between the CPU port, the DMA port, the arbiter and
// the data memory. slave = arbiter view, master = requesters + memory.
interface dm_bus_arbiter_if;

    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dma_req;
    logic        dma_lock;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_byteen;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_lock, dma_addr, dma_wdata, dma_byteen,
        output dma_gnt, dma_rdata, dma_rvalid,
        output mem_addr, mem_wdata, mem_byteen,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_lock, dma_addr, dma_wdata, dma_byteen,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  mem_addr, mem_wdata, mem_byteen,
        output mem_rdata
    );

endinterface

// File: rtl/dm_arb_grant.sv
// Combinational grant decision for the data-memory arbiter.
// At most one of gnt_cpu/gnt_dma is ever high.
module dm_arb_grant
    import dm_arb_pkg::*;
#(
    parameter int BURST_MAX  = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                                cpu_req,
    input  logic                                dma_req,
    input  owner_e                              owner,
    input  logic                                lock_q,
    input  logic [$clog2(BURST_MAX+1)-1:0]      burst_cnt,
    input  logic [$clog2(STARVE_MAX+1)-1:0]     starve_cnt,
    input  logic                                rr_dma,
    output logic                                gnt_cpu,
    output logic                                gnt_dma
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic forced;
    logic hold;
    logic dma_win;

    // A full burst yields exactly one slot to the CPU; the lock survives it.
    always_comb begin
        forced  = lock_q && (burst_cnt >= BMAX);
        hold    = lock_q && (burst_cnt < BMAX) && (owner != OWN_IDLE);
        dma_win = !forced && (hold || (starve_cnt >= SMAX) || rr_dma);
        gnt_cpu = cpu_req && !(dma_req && dma_win);
        gnt_dma = dma_req && !gnt_cpu;
    end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Data-memory port arbiter: CPU M-stage vs DMA/debug loader.
// Define DM_ARB_RR_EN for round-robin contention instead of CPU priority.
module dm_bus_arbiter
    import dm_arb_pkg::*;
#(
    parameter int BURST_MAX  = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            reset,
    dm_bus_arbiter_if.slave bus
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);

    owner_e          owner;
    owner_e          owner_nxt;
    logic            lock_q;
    logic [BW-1:0]   burst_cnt;
    logic [SW-1:0]   starve_cnt;
    logic [31:0]     rdata_q;
    logic            rvalid_q;
    logic            rr_dma;
    logic            cpu_req_g;
    logic            dma_req_g;
    logic            gnt_cpu;
    logic            gnt_dma;

    // Nothing is granted while reset is held, so no write leaks through.
    assign cpu_req_g = bus.cpu_req && !reset;
    assign dma_req_g = bus.dma_req && !reset;

    dm_arb_grant #(
        .BURST_MAX  (BURST_MAX),
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .cpu_req    (cpu_req_g),
        .dma_req    (dma_req_g),
        .owner      (owner),
        .lock_q     (lock_q),
        .burst_cnt  (burst_cnt),
        .starve_cnt (starve_cnt),
        .rr_dma     (rr_dma),
        .gnt_cpu    (gnt_cpu),
        .gnt_dma    (gnt_dma)
    );

`ifdef DM_ARB_RR_EN
    logic rr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else if (cpu_req_g && dma_req_g) begin
            rr_q <= gnt_cpu;
        end
    end

    assign rr_dma = rr_q;
`else
    assign rr_dma = 1'b0;
`endif

    always_comb begin
        owner_nxt      = OWN_IDLE;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_byteen = BYTEEN_NONE;
        unique case (1'b1)
            gnt_cpu: begin
                owner_nxt      = OWN_CPU;
                bus.mem_addr   = word_align(bus.cpu_addr);
                bus.mem_wdata  = bus.cpu_wdata;
                bus.mem_byteen = bus.cpu_byteen;
            end
            gnt_dma: begin
                owner_nxt      = OWN_DMA;
                bus.mem_addr   = word_align(bus.dma_addr);
                bus.mem_wdata  = bus.dma_wdata;
                bus.mem_byteen = bus.dma_byteen;
            end
            default: ;
        endcase
    end

    assign bus.cpu_rdata  = gnt_cpu ? bus.mem_rdata : '0;
    assign bus.cpu_stall  = bus.cpu_req && !gnt_cpu;
    assign bus.dma_gnt    = gnt_dma;
    assign bus.dma_rdata  = rdata_q;
    assign bus.dma_rvalid = rvalid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_IDLE;
            lock_q     <= 1'b0;
            burst_cnt  <= '0;
            starve_cnt <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            owner <= owner_nxt;

            if (gnt_dma) begin
                lock_q <= bus.dma_lock;
            end else if (!bus.dma_req) begin
                lock_q <= 1'b0;
            end

            if (gnt_dma && bus.dma_lock) begin
                if (burst_cnt < BMAX) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                burst_cnt <= '0;
            end

`ifdef DM_ARB_RR_EN
            starve_cnt <= '0;
`else
            if (gnt_dma) begin
                starve_cnt <= '0;
            end else if (bus.dma_req && (starve_cnt < SW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
`endif

            rvalid_q <= gnt_dma && (bus.dma_byteen == BYTEEN_NONE);
            if (gnt_dma && (bus.dma_byteen == BYTEEN_NONE)) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

endmodule
